transmisor_top: RTL and testbench
=================================

# transmisor_top

Transmit-side front end of the 4-lane physical-layer link. Each cycle it selects one byte, either the data byte or one of eight programmable K-symbols, according to a 4-bit control code. It then byte-stripes the selected stream round-robin across four 8-bit lanes. It sits between the link-layer packet source and the per-lane serializers/encoders. Internally it is a registered symbol mux followed by a registered byte-striping stage.

## Interface
Parameters:
- LANES, 4: number of output lanes. Fixed at 4; other values are not supported.
- W, 8: symbol width in bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- enb  in  1  enable; when 0, no new byte is accepted and the lanes hold.
- tx_DataE  in  8  data byte, selected when control_dk=0000.
- com  in  8  COM symbol value (nominal 8'hBC).
- skp  in  8  SKP symbol value (nominal 8'h1C).
- stp  in  8  STP symbol value (nominal 8'hFB).
- sdp  in  8  SDP symbol value (nominal 8'h5C).
- end_ok  in  8  END symbol value (nominal 8'hFD).
- edb  in  8  EDB symbol value (nominal 8'hFE).
- fts  in  8  FTS symbol value (nominal 8'h3C).
- idle  in  8  IDLE symbol value (nominal 8'h7C).
- control_dk  in  4  symbol select code.
- tx_lane0..tx_lane3  out  8 each  striped lane outputs.

## Operation
- Mux decode of control_dk:
  - 0000 → tx_DataE
  - 0001 → com
  - 0010 → skp
  - 0011 → stp
  - 0100 → sdp
  - 0101 → end_ok
  - 0110 → edb
  - 0111 → fts
  - 1000 → idle
  - 1001–1111 → 8'h00 (inactive byte)
- Mux stage registers:
  - tx_mux_out (8 bits) gets the decoded byte.
  - tx_Valid gets enb.
  - Both update every cycle.
- Striping stage:
  - Holds a 2-bit lane pointer ptr.
  - On a cycle with tx_Valid=1, tx_lane[ptr] ← tx_mux_out and ptr ← ptr+1 (modulo 4; 3 wraps to 0).
  - Lanes not addressed in that cycle hold their value.
  - With tx_Valid=0, all lanes and ptr hold.
- The stream order is lane0, lane1, lane2, lane3, lane0, …; a byte is never written to two lanes.
- The symbol inputs are plain data. No checking is done against the nominal values.

## Timing
- Reset, on a rising edge with rst=1:
  - tx_mux_out = 8'h00, tx_Valid = 0, ptr = 0.
  - tx_lane0..3 = 8'h00.
- rst takes priority over enb and control_dk. A byte pending in the mux register at reset is discarded.
- Latency is 2 cycles. When control_dk/enb is sampled at edge N, the byte is latched into the mux register at edge N. It then appears on tx_lane[ptr] after edge N+1.
- After reset is released, the first accepted byte goes to tx_lane0.
- Throughput is one byte per cycle. A given lane refreshes once every 4 accepted bytes.
- enb may toggle on any cycle. A byte accepted while enb=1 is still striped on the following edge even if enb drops. Pointer position is preserved across enb=0 gaps.
- A control_dk value of X or Z is treated as an undefined code. Synthesized behaviour is 8'h00.

## Configuration
- Macro: TX_COM_ALIGN_EN.
- Defined:
  - Any accepted byte whose mux code was 0001 (COM) is written to tx_lane0 regardless of ptr, and ptr ← 1.
  - Every COM therefore starts an aligned lane group.
  - The code is carried in a 1-bit registered flag alongside tx_mux_out.
- Undefined: pure round-robin; COM is striped like any other byte.

## Test plan
- Reset: hold rst=1 for 2 edges with enb=1 → tx_lane0..3 = 00, and the first byte after release lands on lane0.
- IDLE stream: control_dk=1000 for 4 cycles, nominal symbol values → after the 2-cycle latency, lanes 0..3 become 7C in order, one per cycle.
- Packet: COM×4, STP, data×2 (tx_DataE=FF), END → after 4 COM writes: lanes 0..3 = BC. After the next 4 accepted bytes: lane0=FB, lane1=FF, lane2=FF, lane3=FD.
- Wrap and hold: stripe 5 bytes, drop enb for 3 cycles, then send SDP → lanes hold during the gap, and SDP (5C) lands on lane1.
- Unused code: control_dk=1010 → 00 is written to the current lane.
- With TX_COM_ALIGN_EN: send data, data, then COM → BC lands on lane0 (not lane2), and the next byte lands on lane1. Without the macro, BC lands on lane2.

Source files
------------

// File: rtl/transmisor_top.sv
// transmisor_top: registered data/K-symbol mux feeding a registered 4-lane round-robin byte striper.
// Optional macro TX_COM_ALIGN_EN: every accepted COM is forced onto lane0 and restarts the lane group.
module transmisor_top #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic [W-1:0] tx_DataE,
    input  logic [W-1:0] com,
    input  logic [W-1:0] skp,
    input  logic [W-1:0] stp,
    input  logic [W-1:0] sdp,
    input  logic [W-1:0] end_ok,
    input  logic [W-1:0] edb,
    input  logic [W-1:0] fts,
    input  logic [W-1:0] idle,
    input  logic [3:0]   control_dk,
    output logic [W-1:0] tx_lane0,
    output logic [W-1:0] tx_lane1,
    output logic [W-1:0] tx_lane2,
    output logic [W-1:0] tx_lane3
);
    localparam int unsigned PTR_W = $clog2(LANES);

    localparam logic [3:0] CODE_DATA = 4'b0000;
    localparam logic [3:0] CODE_COM  = 4'b0001;
    localparam logic [3:0] CODE_SKP  = 4'b0010;
    localparam logic [3:0] CODE_STP  = 4'b0011;
    localparam logic [3:0] CODE_SDP  = 4'b0100;
    localparam logic [3:0] CODE_END  = 4'b0101;
    localparam logic [3:0] CODE_EDB  = 4'b0110;
    localparam logic [3:0] CODE_FTS  = 4'b0111;
    localparam logic [3:0] CODE_IDLE = 4'b1000;

    logic [W-1:0]     sel_byte_c;
    logic [W-1:0]     tx_mux_out;
    logic             tx_valid;
    logic [PTR_W-1:0] ptr;

    // Symbol decode; unused and undefined codes yield the inactive byte.
    always_comb begin
        sel_byte_c = '0;
        case (control_dk)
            CODE_DATA: sel_byte_c = tx_DataE;
            CODE_COM:  sel_byte_c = com;
            CODE_SKP:  sel_byte_c = skp;
            CODE_STP:  sel_byte_c = stp;
            CODE_SDP:  sel_byte_c = sdp;
            CODE_END:  sel_byte_c = end_ok;
            CODE_EDB:  sel_byte_c = edb;
            CODE_FTS:  sel_byte_c = fts;
            CODE_IDLE: sel_byte_c = idle;
            default:   sel_byte_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_mux_out <= '0;
            tx_valid   <= 1'b0;
        end else begin
            tx_mux_out <= sel_byte_c;
            tx_valid   <= enb;
        end
    end

`ifdef TX_COM_ALIGN_EN
    logic is_com_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_com_q <= 1'b0;
        end else begin
            is_com_q <= (control_dk == CODE_COM);
        end
    end
`endif

    // Striping: one lane written per accepted byte, everything else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            tx_lane0 <= '0;
            tx_lane1 <= '0;
            tx_lane2 <= '0;
            tx_lane3 <= '0;
        end else if (tx_valid) begin
`ifdef TX_COM_ALIGN_EN
            if (is_com_q) begin
                tx_lane0 <= tx_mux_out;
                ptr      <= PTR_W'(1);
            end else
`endif
            begin
                case (ptr)
                    2'd0:    tx_lane0 <= tx_mux_out;
                    2'd1:    tx_lane1 <= tx_mux_out;
                    2'd2:    tx_lane2 <= tx_mux_out;
                    default: tx_lane3 <= tx_mux_out;
                endcase
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_transmisor_top.sv
// Directed self-checking bench for transmisor_top (honours TX_COM_ALIGN_EN when defined).
module tb_transmisor_top;
    logic       clk;
    logic       rst;
    logic       enb;
    logic [7:0] tx_DataE;
    logic [7:0] com, skp, stp, sdp, end_ok, edb, fts, idle;
    logic [3:0] control_dk;
    logic [7:0] tx_lane0, tx_lane1, tx_lane2, tx_lane3;

    int n_vec = 0;
    int n_err = 0;

    transmisor_top #(.LANES(4), .W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .tx_DataE   (tx_DataE),
        .com        (com),
        .skp        (skp),
        .stp        (stp),
        .sdp        (sdp),
        .end_ok     (end_ok),
        .edb        (edb),
        .fts        (fts),
        .idle       (idle),
        .control_dk (control_dk),
        .tx_lane0   (tx_lane0),
        .tx_lane1   (tx_lane1),
        .tx_lane2   (tx_lane2),
        .tx_lane3   (tx_lane3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        check({tag, ".l0"}, tx_lane0, e0);
        check({tag, ".l1"}, tx_lane1, e1);
        check({tag, ".l2"}, tx_lane2, e2);
        check({tag, ".l3"}, tx_lane3, e3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] code, input logic [7:0] data);
        enb        = 1'b1;
        control_dk = code;
        tx_DataE   = data;
        step();
    endtask

    task automatic hold_step();
        enb        = 1'b0;
        control_dk = 4'b1000;
        step();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enb        = 1'b1;
        control_dk = 4'b1000;
        step();
        step();
        rst = 1'b0;
        enb = 1'b0;
    endtask

    initial begin
        com = 8'hBC; skp = 8'h1C; stp = 8'hFB; sdp = 8'h5C;
        end_ok = 8'hFD; edb = 8'hFE; fts = 8'h3C; idle = 8'h7C;
        tx_DataE = 8'h00; control_dk = 4'b1000; enb = 1'b1; rst = 1'b1;

        // Reset held two edges with enb=1
        do_reset();
        check_lanes("reset", 8'h00, 8'h00, 8'h00, 8'h00);

        // IDLE stream: one lane per cycle after 2-cycle latency
        send(4'b1000, 8'h00);
        check_lanes("idle.c1", 8'h00, 8'h00, 8'h00, 8'h00);
        send(4'b1000, 8'h00);
        check_lanes("idle.c2", 8'h7C, 8'h00, 8'h00, 8'h00);
        send(4'b1000, 8'h00);
        check_lanes("idle.c3", 8'h7C, 8'h7C, 8'h00, 8'h00);
        send(4'b1000, 8'h00);
        check_lanes("idle.c4", 8'h7C, 8'h7C, 8'h7C, 8'h00);
        hold_step();
        check_lanes("idle.c5", 8'h7C, 8'h7C, 8'h7C, 8'h7C);

        // Packet: COM x4, STP, FF, FF, END
        send(4'b0001, 8'h00);
        send(4'b0001, 8'h00);
        send(4'b0001, 8'h00);
        send(4'b0001, 8'h00);
        send(4'b0011, 8'h00);
`ifdef TX_COM_ALIGN_EN
        check_lanes("pkt.com", 8'hBC, 8'h7C, 8'h7C, 8'h7C);
`else
        check_lanes("pkt.com", 8'hBC, 8'hBC, 8'hBC, 8'hBC);
`endif
        send(4'b0000, 8'hFF);
        send(4'b0000, 8'hFF);
        send(4'b0101, 8'h00);
        hold_step();
`ifdef TX_COM_ALIGN_EN
        check_lanes("pkt.body", 8'hFD, 8'hFB, 8'hFF, 8'hFF);
`else
        check_lanes("pkt.body", 8'hFB, 8'hFF, 8'hFF, 8'hFD);
`endif

        // Wrap and hold across an enb gap
        do_reset();
        send(4'b0000, 8'h01);
        send(4'b0000, 8'h02);
        send(4'b0000, 8'h03);
        send(4'b0000, 8'h04);
        send(4'b0000, 8'h05);
        check_lanes("wrap.4", 8'h01, 8'h02, 8'h03, 8'h04);
        hold_step();
        check_lanes("wrap.5", 8'h05, 8'h02, 8'h03, 8'h04);
        hold_step();
        hold_step();
        check_lanes("hold", 8'h05, 8'h02, 8'h03, 8'h04);
        send(4'b0100, 8'h00);
        hold_step();
        check_lanes("sdp", 8'h05, 8'h5C, 8'h03, 8'h04);

        // Unused codes write the inactive byte to the current lane
        send(4'b1010, 8'hAA);
        send(4'b1111, 8'hAA);
        hold_step();
        check_lanes("unused", 8'h05, 8'h5C, 8'h00, 8'h00);

        // Every K-symbol code in order
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            send(4'(c), 8'h00);
            if (c == 5) check_lanes("sym.lo", 8'hBC, 8'h1C, 8'hFB, 8'h5C);
        end
        hold_step();
        check_lanes("sym.hi", 8'hFD, 8'hFE, 8'h3C, 8'h7C);

        // A byte pending in the mux register at reset is discarded
        send(4'b0000, 8'h99);
        rst = 1'b1;
        step();
        rst = 1'b0;
        hold_step();
        check_lanes("rst.pend", 8'h00, 8'h00, 8'h00, 8'h00);

        // COM alignment: data, data, COM, data
        do_reset();
        send(4'b0000, 8'h11);
        send(4'b0000, 8'h22);
        send(4'b0001, 8'h00);
        send(4'b0000, 8'h33);
        hold_step();
`ifdef TX_COM_ALIGN_EN
        check_lanes("align", 8'hBC, 8'h33, 8'h00, 8'h00);
`else
        check_lanes("align", 8'h11, 8'h22, 8'hBC, 8'h33);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
